// File: rtl/spm_pipe_mult.sv
// Serial-parallel unsigned multiplier: x held in parallel, y shifted in LSB first
// through a WIDTH-cell carry-save chain. Optional SPM_SERIAL_OUT_EN exposes the raw product bit stream.
module spm_pipe_mult #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(2*WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
`ifdef SPM_SERIAL_OUT_EN
  ,
  output logic               p_bit,
  output logic               p_bit_valid
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*WIDTH-1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     x_reg, y_sh_reg;
  logic [WIDTH-1:0]     sum_reg, carry_reg, sum_next, carry_next;
  logic [2*WIDTH-2:0]   acc_reg;
  logic [2*WIDTH-1:0]   out_p_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 ybit, accept, last_step;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign out_p     = out_p_reg;
  assign accept    = in_valid && in_ready;
  assign last_step = (state_reg == RUN) && (cnt_reg == CNT_LAST);
  assign ybit      = (cnt_reg < CNT_HALF) ? y_sh_reg[0] : 1'b0;

  // Each cell adds its partial-product bit to the sum shifted down from its upper neighbour.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_csa
    logic a_bit, b_bit;
    assign a_bit = x_reg[gi] & ybit;
    if (gi == WIDTH-1) begin : g_top
      assign b_bit = 1'b0;
    end else begin : g_mid
      assign b_bit = sum_reg[gi+1];
    end
    assign {carry_next[gi], sum_next[gi]} = {1'b0, a_bit} + {1'b0, b_bit} + {1'b0, carry_reg[gi]};
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // acc_reg holds the 2W-1 earliest product bits; the last bit joins them straight into out_p.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg     <= '0;
      y_sh_reg  <= '0;
      sum_reg   <= '0;
      carry_reg <= '0;
      acc_reg   <= '0;
      out_p_reg <= '0;
      cnt_reg   <= '0;
    end else if (state_reg == IDLE) begin
      if (accept) begin
        x_reg     <= in_x;
        y_sh_reg  <= in_y;
        sum_reg   <= '0;
        carry_reg <= '0;
        acc_reg   <= '0;
        cnt_reg   <= '0;
      end
    end else if (state_reg == RUN) begin
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      y_sh_reg  <= y_sh_reg >> 1;
      acc_reg   <= {sum_next[0], acc_reg[2*WIDTH-2:1]};
      cnt_reg   <= cnt_reg + CNT_ONE;
      if (last_step) out_p_reg <= {sum_next[0], acc_reg};
    end
  end

`ifdef SPM_SERIAL_OUT_EN
  logic p_bit_reg, p_bit_valid_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      p_bit_reg       <= 1'b0;
      p_bit_valid_reg <= 1'b0;
    end else begin
      p_bit_reg       <= (state_reg == RUN) ? sum_next[0] : 1'b0;
      p_bit_valid_reg <= (state_reg == RUN);
    end
  end
  assign p_bit       = p_bit_reg;
  assign p_bit_valid = p_bit_valid_reg;
`endif

`ifndef SYNTHESIS
  a_carry_drained: assert property (@(posedge clk) disable iff (rst)
    (state_reg == DONE) |-> (carry_reg == '0));
`endif

endmodule

// File: doc/spm_pipe_mult.md
Name: spm_pipe_mult

Overview:
- Parametrised successor to the fixed-width serial-parallel multiplier (spm) cells.
- Multiplicand x is held in parallel. Multiplier y is shifted in serially, LSB first, through a WIDTH-cell carry-save adder (CSA) chain.
- Produces a 2*WIDTH-bit unsigned product.
- Wrapped in a valid/ready request/response handshake so it can sit between stream stages and be equivalence-checked per CSA cell.

Parameters:
- WIDTH, 8: operand width in bits; legal range 2..64.
- CNT_W, $clog2(2*WIDTH+1): cycle-counter width; derived, not overridden.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operand pair valid.
- in_ready, output, 1: block accepts operands (high only in IDLE).
- in_x, input, WIDTH: multiplicand, parallel.
- in_y, input, WIDTH: multiplier, consumed serially, LSB first.
- out_valid, output, 1: product valid.
- out_ready, input, 1: consumer accepts product.
- out_p, output, 2*WIDTH: product in_x*in_y.
- busy, output, 1: high in RUN or DONE.

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE; in_ready=1; out_valid=0; out_p=0; busy=0.
  - All CSA sum/carry regs, y shift reg and counter cleared.
  - rst overrides every other input in the same cycle, including mid-RUN and in DONE. Any in-flight operation is discarded with no output.
- States IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch x_reg=in_x, y_sh=in_y; clear CSA regs; cnt=0; go to RUN.
  - out_p keeps its previous value but is don't-care while out_valid=0.
- RUN, one cycle per step, cnt=0..2*WIDTH-1:
  - Serial input bit ybit = y_sh[0] while cnt<WIDTH, else 0; y_sh shifts right each cycle.
  - CSA cell i (0..WIDTH-1): a_i = x_reg[i]&ybit; b_i = sum_reg[i+1] (cell WIDTH-1 uses 0); {carry_reg[i], sum_reg[i]} <= a_i + b_i + carry_reg[i].
  - Product bit p_bit = sum of cell 0 after update. It shifts into acc from the MSB side: acc <= {p_bit, acc[2W-1:1]}.
  - When cnt==2*WIDTH-1: out_p <= final acc; go to DONE.
  - in_ready=0 throughout.
- DONE:
  - out_valid=1; out_p held stable until out_valid&&out_ready.
  - On handshake: go to IDLE. in_ready rises the next cycle (no same-cycle accept in DONE).
- Latency: accept at edge E; out_valid first high in the cycle after edge E+2*WIDTH. Throughput is one product per 2*WIDTH+1 cycles plus stall.
- Arithmetic: unsigned, exact, no truncation. Max 2^(2W)-2^(W+1)+1 fits 2*WIDTH bits. All CSA carries are drained to zero by end of RUN; a nonzero carry in DONE is a bug (assertion).
- in_x/in_y changes after accept have no effect. in_valid while busy is ignored, not queued.
- out_ready high in IDLE or RUN: no effect.

Optional Feature:
- Macro: SPM_SERIAL_OUT_EN.
- When defined, two extra outputs are added:
  - p_bit (1): raw product bit, LSB first, each RUN cycle.
  - p_bit_valid (1): high exactly during the 2*WIDTH RUN cycles.
  - Both reset to 0. Both are combinational from the CSA cell 0 next-state, registered once, so they trail by one cycle: valid on cycles E+1..E+2*WIDTH.
- Undefined: ports absent. Parallel behaviour is identical in both builds.

Test Plan:
- WIDTH=8, rst 2 cycles, then in_x=13, in_y=11, out_ready=1 -> out_valid first high exactly 17 cycles after accept edge, out_p=143, in_ready low whole time.
- WIDTH=8, in_x=255, in_y=255 -> out_p=65025. Also in_x=0, in_y=200 -> out_p=0. Also in_x=1, in_y=1 -> out_p=1.
- WIDTH=8, out_ready held 0 for 10 cycles in DONE -> out_p=143 stable, out_valid=1, in_ready=0. Release -> in_ready=1 next cycle; a back-to-back second request 7*9 -> 63.
- WIDTH=8, rst asserted at RUN cycle 5 of 200*3 -> next cycle IDLE, out_valid=0, out_p=0. Fresh 6*7 -> 42 with normal latency.
- WIDTH=32, 1000 random pairs vs reference multiply -> all match; latency 65 each.
- SPM_SERIAL_OUT_EN, WIDTH=4, 5*3 -> p_bit sequence 1,1,1,1,0,0,0,0 with p_bit_valid high for exactly 8 cycles. Macro undefined -> same out_p=15.
